// File: rtl/aemb_ifetch_if.sv
// Instruction-side Wishbone classic read bus between fetch stage and memory.
interface aemb_ifetch_if #(
  parameter int unsigned AW = 32
);
  logic [AW-1:0] iwb_adr_o;
  logic          iwb_stb_o;
  logic [31:0]   iwb_dat_i;
  logic          iwb_ack_i;

  modport master (
    output iwb_adr_o,
    output iwb_stb_o,
    input  iwb_dat_i,
    input  iwb_ack_i
  );

  modport slave (
    input  iwb_adr_o,
    input  iwb_stb_o,
    output iwb_dat_i,
    output iwb_ack_i
  );
endinterface

// File: rtl/aemb_ifetch.sv
// Instruction fetch/prefetch: issues single-word reads, queues {word, pc},
// and flushes/redirects on a taken branch.
module aemb_ifetch #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DLOG     = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          gena,
  input  logic          rBRA,
  input  logic [AW-1:0] rTGT,
  aemb_ifetch_if.master iwb,
  output logic [31:0]   inst_o,
  output logic [AW-1:0] pc_o,
  output logic          inst_vld_o
);

  localparam int unsigned DEPTH = 1 << DLOG;
  localparam int unsigned CW    = DLOG + 1;
  localparam int unsigned PW    = AW - 2;
  localparam logic [31:0] NOP   = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_fpc;
  logic [AW-1:0]   w_fpc_nxt;
  logic [AW-1:0]   r_adr;
  logic            r_stb;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_cnt_nxt;
  logic [DLOG-1:0] r_wptr;
  logic [DLOG-1:0] r_rptr;
  logic [AW-1:0]   r_pc_hold;
  logic [31:0]     r_mem_word [DEPTH];
  logic [PW-1:0]   r_mem_pc   [DEPTH];

  logic w_redir;
  logic w_push;
  logic w_pop;
  logic w_vld;
  logic w_unused;

  // Low target bits are forced to word alignment and never read.
  assign w_unused = &{1'b0, rTGT[1:0]};

  // Handshake qualifiers; a redirect cancels any same-cycle push or pop.
  assign w_vld   = (r_count != '0);
  assign w_redir = gena & rBRA;
  assign w_push  = (r_state == BUSY) & iwb.iwb_ack_i & ~w_redir;
  assign w_pop   = gena & w_vld & ~w_redir;
  assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Head-of-queue presentation; pc holds its last value while empty.
  assign inst_vld_o = w_vld;
  assign inst_o     = w_vld ? r_mem_word[r_rptr] : NOP;
  assign pc_o       = w_vld ? {r_mem_pc[r_rptr], 2'b00} : r_pc_hold;

  assign iwb.iwb_adr_o = r_adr;
  assign iwb.iwb_stb_o = r_stb;

  // Next-state and next fetch address; redirect overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_fpc_nxt   = r_fpc;
    unique case (r_state)
      IDLE: begin
        if (w_cnt_nxt < CW'(DEPTH)) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (iwb.iwb_ack_i) begin
          w_fpc_nxt   = r_fpc + AW'(4);
          w_state_nxt = (w_cnt_nxt < CW'(DEPTH)) ? BUSY : IDLE;
        end
      end
      DISCARD: begin
        if (iwb.iwb_ack_i) w_state_nxt = BUSY;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_redir) begin
      w_fpc_nxt = {rTGT[AW-1:2], 2'b00};
      unique case (r_state)
        IDLE:    w_state_nxt = BUSY;
        BUSY:    w_state_nxt = iwb.iwb_ack_i ? BUSY : DISCARD;
        DISCARD: w_state_nxt = DISCARD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State, fetch pointer, bus outputs and queue bookkeeping.
  always_ff @(posedge gclk) begin
    if (grst) begin
      r_state   <= IDLE;
      r_fpc     <= RESET_PC;
      r_adr     <= RESET_PC;
      r_stb     <= 1'b0;
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pc_hold <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fpc   <= w_fpc_nxt;
      r_stb   <= (w_state_nxt != IDLE);
      // A discarded read keeps its stale address until it is acked.
      if (w_state_nxt != DISCARD) r_adr <= w_fpc_nxt;
      if (w_vld) r_pc_hold <= {r_mem_pc[r_rptr], 2'b00};
      if (w_redir) begin
        r_count <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
      end else begin
        r_count <= w_cnt_nxt;
        if (w_push) r_wptr <= r_wptr + DLOG'(1);
        if (w_pop)  r_rptr <= r_rptr + DLOG'(1);
      end
    end
  end

  // Queue storage; contents are meaningful only between the pointers.
  always_ff @(posedge gclk) begin
    if (w_push) begin
      r_mem_word[r_wptr] <= iwb.iwb_dat_i;
      r_mem_pc[r_wptr]   <= r_fpc[AW-1:2];
    end
  end

endmodule

// File: tb/tb_aemb_ifetch.sv
// Directed bench for aemb_ifetch with a latency-programmable memory model.
module tb_aemb_ifetch;

  logic        gclk;
  logic        grst;
  logic        gena;
  logic        rBRA;
  logic [31:0] rTGT;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_vld_o;

  int   checks = 0;
  int   errors = 0;
  int   lat    = 0;
  int   wcnt   = 0;
  bit   ack_mode = 1'b0;
  logic ack_man  = 1'b0;
  logic [63:0] sb_q [$];

  aemb_ifetch_if #(.AW(32)) bus ();

  aemb_ifetch #(.AW(32), .DLOG(2), .RESET_PC(32'h0)) dut (
    .gclk       (gclk),
    .grst       (grst),
    .gena       (gena),
    .rBRA       (rBRA),
    .rTGT       (rTGT),
    .iwb        (bus),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .inst_vld_o (inst_vld_o)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // Memory model: mem[a] = a ^ A5A50000, ack after lat wait cycles.
  assign bus.iwb_dat_i = bus.iwb_adr_o ^ 32'hA5A5_0000;
  assign bus.iwb_ack_i = ack_mode ? ack_man : (bus.iwb_stb_o && (wcnt >= lat));

  always @(posedge gclk) begin
    if (!bus.iwb_stb_o || bus.iwb_ack_i) wcnt <= 0;
    else                                 wcnt <= wcnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    sb_q.push_back({pc, pc ^ 32'hA5A5_0000});
  endtask

  // Consume n words; gena stays high at exit so the last compared word pops.
  task automatic consume(input int n, output int cyc);
    int done;
    logic [63:0] e;
    done = 0;
    cyc  = 0;
    while (done < n && cyc < 40) begin
      @(negedge gclk);
      cyc++;
      gena = 1'b1;
      if (inst_vld_o) begin
        e = (sb_q.size() != 0) ? sb_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        chk("word", {pc_o, inst_o}, e);
        done++;
      end
    end
    if (done < n) chk("consume_timeout", 64'(done), 64'(n));
  endtask

  task automatic do_reset();
    grst = 1'b1;
    gena = 1'b0;
    rBRA = 1'b0;
    repeat (2) @(negedge gclk);
    sb_q.delete();
    grst = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    for (int k = 0; k < 12 && !bus.iwb_ack_i; k++) @(negedge gclk);
    chk(tag, 64'(bus.iwb_ack_i), 64'(1));
  endtask

  initial begin
    int cyc;
    grst = 1'b1; gena = 1'b0; rBRA = 1'b0; rTGT = '0;
    repeat (3) @(negedge gclk);
    chk("rst_stb",  64'(bus.iwb_stb_o), 64'(0));
    chk("rst_adr",  64'(bus.iwb_adr_o), 64'(0));
    chk("rst_vld",  64'(inst_vld_o),    64'(0));
    chk("rst_inst", 64'(inst_o),        64'h8000_0000);
    chk("rst_pc",   64'(pc_o),          64'(0));

    // Reset release, fill with gena=0, address sequence 0,4,8,C
    grst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge gclk);
      chk("fill_stb", 64'(bus.iwb_stb_o), 64'(1));
      chk("fill_adr", 64'(bus.iwb_adr_o), 64'(4 * (i - 1)));
      chk("fill_vld", 64'(inst_vld_o), 64'(i >= 2));
    end
    chk("first_head", {pc_o, inst_o}, {32'h0, 32'hA5A5_0000});
    repeat (6) @(negedge gclk);
    chk("full_stb", 64'(bus.iwb_stb_o), 64'(0));
    chk("full_adr", 64'(bus.iwb_adr_o), 64'h10);

    // Drain: stb returns the cycle after the first pop
    expect_word(32'h0);
    consume(1, cyc);
    @(negedge gclk);
    gena = 1'b0;
    chk("restart_stb", 64'(bus.iwb_stb_o), 64'(1));
    chk("restart_adr", 64'(bus.iwb_adr_o), 64'h10);
    for (int i = 1; i < 8; i++) expect_word(32'(4 * i));
    consume(7, cyc);
    chk("sustained", 64'(cyc), 64'(7));
    @(negedge gclk); gena = 1'b0;

    // Redirect mid-wait with a 3-cycle slave
    lat = 3;
    do_reset();
    repeat (2) @(negedge gclk);
    gena = 1'b1; rBRA = 1'b1; rTGT = 32'h100;
    @(negedge gclk);
    gena = 1'b0; rBRA = 1'b0;
    chk("disc_stb", 64'(bus.iwb_stb_o), 64'(1));
    chk("disc_adr", 64'(bus.iwb_adr_o), 64'(0));
    wait_ack("disc_ack");
    chk("disc_adr_ack", 64'(bus.iwb_adr_o), 64'(0));
    @(negedge gclk);
    chk("redir_adr", 64'(bus.iwb_adr_o), 64'h100);
    chk("redir_vld", 64'(inst_vld_o), 64'(0));
    expect_word(32'h100);
    consume(1, cyc);
    @(negedge gclk); gena = 1'b0;

    // Redirect coincident with ack, two entries queued
    lat = 0;
    do_reset();
    repeat (3) @(negedge gclk);
    chk("pre_vld", 64'(inst_vld_o), 64'(1));
    chk("pre_adr", 64'(bus.iwb_adr_o), 64'h8);
    gena = 1'b1; rBRA = 1'b1; rTGT = 32'h203;
    @(negedge gclk);
    gena = 1'b0; rBRA = 1'b0;
    chk("flush_vld",  64'(inst_vld_o),    64'(0));
    chk("flush_inst", 64'(inst_o),        64'h8000_0000);
    chk("flush_pc",   64'(pc_o),          64'(0));
    chk("flush_adr",  64'(bus.iwb_adr_o), 64'h200);
    expect_word(32'h200);
    expect_word(32'h204);
    consume(2, cyc);
    @(negedge gclk); gena = 1'b0;

    // Reset mid-transfer, late ack ignored
    ack_mode = 1'b1; ack_man = 1'b0;
    do_reset();
    @(negedge gclk);
    ack_man = 1'b1;
    @(negedge gclk);
    ack_man = 1'b0;
    chk("mr_vld", 64'(inst_vld_o), 64'(1));
    chk("mr_adr", 64'(bus.iwb_adr_o), 64'h4);
    grst = 1'b1;
    @(negedge gclk);
    chk("mr_rst_stb",  64'(bus.iwb_stb_o), 64'(0));
    chk("mr_rst_adr",  64'(bus.iwb_adr_o), 64'(0));
    chk("mr_rst_vld",  64'(inst_vld_o),    64'(0));
    chk("mr_rst_inst", 64'(inst_o),        64'h8000_0000);
    grst = 1'b0; ack_man = 1'b1;
    @(negedge gclk);
    chk("late_stb", 64'(bus.iwb_stb_o), 64'(1));
    chk("late_adr", 64'(bus.iwb_adr_o), 64'(0));
    chk("late_vld", 64'(inst_vld_o), 64'(0));
    ack_man = 1'b0; ack_mode = 1'b0;
    expect_word(32'h0);
    consume(1, cyc);
    @(negedge gclk); gena = 1'b0;

    // Two redirects while discarding; last target wins
    lat = 3;
    do_reset();
    repeat (2) @(negedge gclk);
    gena = 1'b1; rBRA = 1'b1; rTGT = 32'h40;
    @(negedge gclk);
    rTGT = 32'h80;
    chk("dd_adr", 64'(bus.iwb_adr_o), 64'(0));
    @(negedge gclk);
    gena = 1'b0; rBRA = 1'b0;
    wait_ack("dd_ack");
    @(negedge gclk);
    chk("dd_tgt", 64'(bus.iwb_adr_o), 64'h80);
    expect_word(32'h80);
    expect_word(32'h84);
    consume(2, cyc);
    @(negedge gclk); gena = 1'b0;

    // Fetch address wraps at the top of the address space
    lat = 0;
    do_reset();
    @(negedge gclk);
    gena = 1'b1; rBRA = 1'b1; rTGT = 32'hFFFF_FFFE;
    @(negedge gclk);
    gena = 1'b0; rBRA = 1'b0;
    chk("wrap_adr", 64'(bus.iwb_adr_o), 64'hFFFF_FFFC);
    expect_word(32'hFFFF_FFFC);
    expect_word(32'h0);
    consume(2, cyc);
    @(negedge gclk); gena = 1'b0;
    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
